// File: rtl/fetch_unit_if.sv
// Instruction-memory fetch channel: one request at a time, completed by ready.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;

    modport master (output imem_req, output imem_addr, input imem_rdata, input imem_ready);
    modport slave  (input imem_req, input imem_addr, output imem_rdata, output imem_ready);
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the PC, fetches over the imem channel and
// resolves jump/jr/branch decisions from the control unit into the next PC.
module fetch_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [5:0]  SYSCALL_FUNC = 6'h0C
) (
    input  logic               clk,
    input  logic               reset,
    fetch_unit_if.master       imem,
    output logic [31:0]        o_inst,
    output logic               o_inst_valid,
    output logic [5:0]         o_opcode,
    output logic [5:0]         o_func,
    output logic [31:0]        o_pc,
    output logic [31:0]        o_pc_plus4,
    input  logic               i_advance,
    input  logic               i_jump,
    input  logic               i_jump_reg,
    input  logic               i_branch,
    input  logic               i_branch_taken,
    input  logic [31:0]        i_rs_value,
    output logic               o_halted,
    output logic               o_fault
);

    typedef enum logic [1:0] {S_FETCH, S_HOLD, S_HALT, S_FAULT} state_t;

    state_t             r_state;
    logic [31:0]        r_pc;
    logic [31:0]        r_inst;
    logic               r_inst_valid;
    logic               r_halted;
    logic               r_fault;
    logic               r_req;

    logic [31:0]        w_pc_plus4;
    logic signed [31:0] w_br_off;
    logic [31:0]        w_next_pc;
    logic               w_is_syscall;

    assign w_pc_plus4   = r_pc + 32'd4;
    assign w_br_off     = {{14{r_inst[15]}}, r_inst[15:0], 2'b00};
    assign w_is_syscall = (r_inst[31:26] == 6'h00) && (r_inst[5:0] == SYSCALL_FUNC);

    always_comb begin
        w_next_pc = w_pc_plus4;
        if (i_jump && i_jump_reg)
            w_next_pc = i_rs_value;
        else if (i_jump)
            w_next_pc = {w_pc_plus4[31:28], r_inst[25:0], 2'b00};
        else if (i_branch && i_branch_taken)
            w_next_pc = w_pc_plus4 + $unsigned(w_br_off);
    end

    // Request is raised one cycle after entering FETCH from reset, and on the
    // advance edge otherwise, so imem_addr is already stable when it goes high.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_FETCH;
            r_pc         <= RESET_PC;
            r_inst       <= 32'h0;
            r_inst_valid <= 1'b0;
            r_halted     <= 1'b0;
            r_fault      <= 1'b0;
            r_req        <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (!r_req) begin
                        r_req <= 1'b1;
                    end else if (imem.imem_ready) begin
                        r_inst       <= imem.imem_rdata;
                        r_inst_valid <= 1'b1;
                        r_req        <= 1'b0;
                        r_state      <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (i_advance) begin
                        r_inst_valid <= 1'b0;
                        if (w_is_syscall) begin
                            r_halted <= 1'b1;
                            r_state  <= S_HALT;
                        end else if (w_next_pc[1:0] != 2'b00) begin
                            r_fault <= 1'b1;
                            r_state <= S_FAULT;
                        end else begin
                            r_pc    <= w_next_pc;
                            r_req   <= 1'b1;
                            r_state <= S_FETCH;
                        end
                    end
                end
                default: begin
                    r_req        <= 1'b0;
                    r_inst_valid <= 1'b0;
                end
            endcase
        end
    end

    assign imem.imem_req  = r_req;
    assign imem.imem_addr = r_pc;
    assign o_inst         = r_inst;
    assign o_inst_valid   = r_inst_valid;
    assign o_opcode       = r_inst[31:26];
    assign o_func         = r_inst[5:0];
    assign o_pc           = r_pc;
    assign o_pc_plus4     = w_pc_plus4;
    assign o_halted       = r_halted;
    assign o_fault        = r_fault;

endmodule
